squash_arbiter: RTL and testbench
=================================

Name: squash_arbiter

Overview:
- Collects squash candidates from branch-unit writebacks (mispredicts) and memory-ordering violation reports.
- Tracks the single oldest outstanding candidate by ROB age.
- Issues one squash packet (dueToBranch / dueToViolation, branch_taken, arch_pc, store/load foldpc) only when the ROB retires the candidate's rob index.
- Sits between the BRU/LSU writeback paths and the ROB commit stage; its output drives the core-wide squash broadcast.

Parameters:
- NUM_BRU, 2, number of branch writeback ports
- ROB_IDX_W, 7, rob index width including MSB wrap flag
- FOLDPC_W, 10, memdep fold-pc width (matches MEMDEP_FOLDPC_WIDTH)
- XLEN, 64, pc width
- FLUSH_CYCLES, 3, cycles after a squash during which new candidates are dropped

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- i_bru_vld  in  NUM_BRU  branch writeback valid per port
- i_bru_mispred  in  NUM_BRU  writeback is a mispredict
- i_bru_taken  in  NUM_BRU  branch actually taken
- i_bru_rob_idx  in  NUM_BRU*ROB_IDX_W  rob index per port
- i_bru_npc  in  NUM_BRU*XLEN  corrected next pc per port
- i_viol_vld  in  1  load/store ordering violation report
- i_viol_rob_idx  in  ROB_IDX_W  rob index of the violating load
- i_viol_load_pc  in  XLEN  pc of the violating load
- i_viol_store_foldpc  in  FOLDPC_W  store foldpc
- i_viol_load_foldpc  in  FOLDPC_W  load foldpc
- i_commit_vld  in  1  ROB retiring an instruction this cycle (oldest slot)
- i_commit_rob_idx  in  ROB_IDX_W  rob index being retired
- o_squash_vld  out  1  squash broadcast, single-cycle pulse
- o_squash_branch  out  1  dueToBranch
- o_squash_viol  out  1  dueToViolation
- o_squash_taken  out  1  branch_taken
- o_squash_pc  out  XLEN  arch_pc to redirect to
- o_squash_store_foldpc  out  FOLDPC_W  violation info
- o_squash_load_foldpc  out  FOLDPC_W  violation info
- o_pending  out  1  a candidate is held
- o_pending_rob_idx  out  ROB_IDX_W  held candidate index (used by the ROB to block commit past it)

Behaviour:
- Age compare: A older than B iff (flagA==flagB && idxA<idxB) || (flagA!=flagB && idxA>idxB). flag is the MSB; idx is the remaining bits.
- Candidate selection per cycle:
  - Valid candidates are BRU ports with vld&mispred, plus the violation port.
  - Pick the oldest. On equal index, a branch beats a violation; among branches, the lower port wins.
- State machine IDLE / PEND / FLUSH:
  - IDLE: a valid candidate is latched into the pending register -> PEND.
  - PEND: if a new candidate is strictly older than the held one, replace it; equal or younger is dropped. If i_commit_vld && i_commit_rob_idx==held, then o_squash_vld=1 next cycle (registered), the packet comes from the held entry, the pending entry clears -> FLUSH.
  - Same-cycle commit match and older new candidate: the commit match wins; the new candidate is dropped (it is younger than the retiring instruction by construction, so it is flushed anyway).
  - FLUSH: all candidates are ignored. A counter runs FLUSH_CYCLES; at expiry -> IDLE.
- Packet contents:
  - Branch: arch_pc = npc, taken = i_bru_taken, viol=0, foldpcs=0.
  - Violation: arch_pc = load pc (re-execute the load), branch=0, taken=0, foldpcs latched.
- Latency: candidate to pending takes 1 cycle; commit match to o_squash_vld takes 1 cycle.
- o_squash_vld is high for exactly 1 cycle per squash.
- Commit of a non-matching index has no effect.
- Reset: asynchronous, active-high. State=IDLE, counter=0, all outputs 0 (o_squash_*, o_pending, o_pending_rob_idx=0). Reset mid-PEND or mid-FLUSH discards everything with no squash pulse.
- Wrap-around: indices on opposite flag parity are compared per the rule above. Held index 0x7F vs new 0x00 (flag differs, idx 0x3F vs 0x00): 0x7F is older.

Optional Feature:
- Macro SQUASH_ARBITER_PERF_EN.
- Defined: adds outputs o_perf_br_squash and o_perf_viol_squash (32-bit each, saturating, reset 0). They increment on each squash pulse of the corresponding cause. Also adds o_perf_replaced (32-bit), which counts pending replacements.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Mispredict on port0 with rob 0x05, npc 0x8000_1000, taken=1; commit 0x05 three cycles later -> next cycle o_squash_vld=1, branch=1, pc 0x8000_1000, taken=1. Then 3 cycles of FLUSH, then IDLE.
- Same cycle: port0 rob 0x10 and port1 rob 0x0C (both mispredicts) -> pending 0x0C. Commit 0x10 -> no squash; commit 0x0C -> squash with port1's npc.
- Pending branch 0x20, then violation at rob 0x1A (load pc 0x8000_2000, foldpcs 0x155/0x2AA) -> pending replaced. Commit 0x1A -> viol=1, pc 0x8000_2000, foldpcs 0x155/0x2AA.
- Wrap: pending 0x7E; new candidate 0x01 -> ignored (younger). Pending 0x01; new 0x7E -> replaced.
- Candidate arriving during FLUSH -> dropped. o_pending stays 0 and no later squash occurs.
- Assert rst while in PEND with o_pending=1 -> all outputs 0 immediately; a later commit of the old index produces no squash.

Source files
------------

// File: rtl/squash_arbiter.sv
// squash_arbiter
// Collects squash candidates from branch mispredict writebacks and memory
// ordering violation reports, keeps the single oldest one by ROB age, and
// broadcasts a one-cycle squash packet when the ROB retires that index.
// After a squash, new candidates are ignored for FLUSH_CYCLES cycles.
//
// Optional build macro: SQUASH_ARBITER_PERF_EN
//   Adds saturating 32-bit counters for branch squashes, violation squashes
//   and pending-entry replacements.
module squash_arbiter #(
  parameter int NUM_BRU      = 2,
  parameter int ROB_IDX_W    = 7,
  parameter int FOLDPC_W     = 10,
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BRU-1:0]           i_bru_vld,
  input  logic [NUM_BRU-1:0]           i_bru_mispred,
  input  logic [NUM_BRU-1:0]           i_bru_taken,
  input  logic [NUM_BRU*ROB_IDX_W-1:0] i_bru_rob_idx,
  input  logic [NUM_BRU*XLEN-1:0]      i_bru_npc,
  input  logic                         i_viol_vld,
  input  logic [ROB_IDX_W-1:0]         i_viol_rob_idx,
  input  logic [XLEN-1:0]              i_viol_load_pc,
  input  logic [FOLDPC_W-1:0]          i_viol_store_foldpc,
  input  logic [FOLDPC_W-1:0]          i_viol_load_foldpc,
  input  logic                         i_commit_vld,
  input  logic [ROB_IDX_W-1:0]         i_commit_rob_idx,
  output logic                         o_squash_vld,
  output logic                         o_squash_branch,
  output logic                         o_squash_viol,
  output logic                         o_squash_taken,
  output logic [XLEN-1:0]              o_squash_pc,
  output logic [FOLDPC_W-1:0]          o_squash_store_foldpc,
  output logic [FOLDPC_W-1:0]          o_squash_load_foldpc,
  output logic                         o_pending,
  output logic [ROB_IDX_W-1:0]         o_pending_rob_idx
`ifdef SQUASH_ARBITER_PERF_EN
  ,
  output logic [31:0]                  o_perf_br_squash,
  output logic [31:0]                  o_perf_viol_squash,
  output logic [31:0]                  o_perf_replaced
`endif
);

  // The flush counter is loaded with FLUSH_CYCLES-1 and counts down to zero,
  // so the FSM spends exactly FLUSH_CYCLES cycles in ST_FLUSH.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;

  // Held candidate payload (valid/index live in o_pending/o_pending_rob_idx)
  logic               held_branch;
  logic               held_taken;
  logic [XLEN-1:0]    held_pc;
  logic [FOLDPC_W-1:0] held_sfold;
  logic [FOLDPC_W-1:0] held_lfold;

  // Oldest candidate presented this cycle
  logic                cand_vld;
  logic [ROB_IDX_W-1:0] cand_idx;
  logic                cand_branch;
  logic                cand_taken;
  logic [XLEN-1:0]     cand_pc;
  logic [FOLDPC_W-1:0] cand_sfold;
  logic [FOLDPC_W-1:0] cand_lfold;
  logic                take_bru;
  logic                take_viol;

  logic                commit_hit;
  logic                load_new;
  logic                replace;

  // ROB age compare: the MSB is the wrap flag, the rest is the slot index.
  // With equal flags the smaller slot is older; with differing flags the
  // larger slot is older because the other index has already wrapped.
  function automatic logic is_older(input logic [ROB_IDX_W-1:0] a,
                                    input logic [ROB_IDX_W-1:0] b);
    logic same_flag;
    same_flag = (a[ROB_IDX_W-1] == b[ROB_IDX_W-1]);
    if (same_flag) begin
      return (a[ROB_IDX_W-2:0] < b[ROB_IDX_W-2:0]);
    end else begin
      return (a[ROB_IDX_W-2:0] > b[ROB_IDX_W-2:0]);
    end
  endfunction

  // Pick the oldest candidate; a later source only wins if strictly older,
  // which gives lower BRU ports priority and branches priority over violations.
  always_comb begin
    cand_vld    = 1'b0;
    cand_idx    = '0;
    cand_branch = 1'b0;
    cand_taken  = 1'b0;
    cand_pc     = '0;
    cand_sfold  = '0;
    cand_lfold  = '0;
    take_bru    = 1'b0;
    for (int p = 0; p < NUM_BRU; p++) begin
      take_bru = i_bru_vld[p] & i_bru_mispred[p] &
                 (~cand_vld | is_older(i_bru_rob_idx[p*ROB_IDX_W +: ROB_IDX_W], cand_idx));
      cand_vld    = cand_vld | take_bru;
      cand_idx    = take_bru ? i_bru_rob_idx[p*ROB_IDX_W +: ROB_IDX_W] : cand_idx;
      cand_branch = cand_branch | take_bru;
      cand_taken  = take_bru ? i_bru_taken[p] : cand_taken;
      cand_pc     = take_bru ? i_bru_npc[p*XLEN +: XLEN] : cand_pc;
    end
    take_viol   = i_viol_vld & (~cand_vld | is_older(i_viol_rob_idx, cand_idx));
    cand_vld    = cand_vld | take_viol;
    cand_idx    = take_viol ? i_viol_rob_idx : cand_idx;
    cand_branch = take_viol ? 1'b0 : cand_branch;
    cand_taken  = take_viol ? 1'b0 : cand_taken;
    cand_pc     = take_viol ? i_viol_load_pc : cand_pc;
    cand_sfold  = take_viol ? i_viol_store_foldpc : cand_sfold;
    cand_lfold  = take_viol ? i_viol_load_foldpc : cand_lfold;
  end

  // Commit match takes precedence over any new candidate in the same cycle.
  always_comb begin
    commit_hit = (state == ST_PEND) & i_commit_vld &
                 (i_commit_rob_idx == o_pending_rob_idx);
    load_new   = cand_vld &
                 ((state == ST_IDLE) |
                  ((state == ST_PEND) & ~commit_hit & is_older(cand_idx, o_pending_rob_idx)));
    replace    = load_new & (state == ST_PEND);
  end

  // Main FSM: pending entry, flush countdown and registered squash packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= ST_IDLE;
      flush_cnt             <= '0;
      held_branch           <= 1'b0;
      held_taken            <= 1'b0;
      held_pc               <= '0;
      held_sfold            <= '0;
      held_lfold            <= '0;
      o_pending             <= 1'b0;
      o_pending_rob_idx     <= '0;
      o_squash_vld          <= 1'b0;
      o_squash_branch       <= 1'b0;
      o_squash_viol         <= 1'b0;
      o_squash_taken        <= 1'b0;
      o_squash_pc           <= '0;
      o_squash_store_foldpc <= '0;
      o_squash_load_foldpc  <= '0;
    end else begin
      o_squash_vld          <= 1'b0;
      o_squash_branch       <= 1'b0;
      o_squash_viol         <= 1'b0;
      o_squash_taken        <= 1'b0;
      o_squash_pc           <= '0;
      o_squash_store_foldpc <= '0;
      o_squash_load_foldpc  <= '0;
      if (load_new) begin
        o_pending         <= 1'b1;
        o_pending_rob_idx <= cand_idx;
        held_branch       <= cand_branch;
        held_taken        <= cand_taken;
        held_pc           <= cand_pc;
        held_sfold        <= cand_sfold;
        held_lfold        <= cand_lfold;
      end
      case (state)
        ST_IDLE: begin
          if (load_new) begin
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (commit_hit) begin
            o_squash_vld          <= 1'b1;
            o_squash_branch       <= held_branch;
            o_squash_viol         <= ~held_branch;
            o_squash_taken        <= held_taken;
            o_squash_pc           <= held_pc;
            o_squash_store_foldpc <= held_sfold;
            o_squash_load_foldpc  <= held_lfold;
            o_pending             <= 1'b0;
            o_pending_rob_idx     <= '0;
            flush_cnt             <= FLUSH_LAST;
            state                 <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state             <= ST_IDLE;
          flush_cnt         <= '0;
          o_pending         <= 1'b0;
          o_pending_rob_idx <= '0;
        end
      endcase
    end
  end

`ifdef SQUASH_ARBITER_PERF_EN
  // Saturating event counters for squash causes and pending replacements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_perf_br_squash   <= 32'd0;
      o_perf_viol_squash <= 32'd0;
      o_perf_replaced    <= 32'd0;
    end else begin
      if (commit_hit && held_branch && (o_perf_br_squash != 32'hFFFF_FFFF)) begin
        o_perf_br_squash <= o_perf_br_squash + 32'd1;
      end
      if (commit_hit && !held_branch && (o_perf_viol_squash != 32'hFFFF_FFFF)) begin
        o_perf_viol_squash <= o_perf_viol_squash + 32'd1;
      end
      if (replace && (o_perf_replaced != 32'hFFFF_FFFF)) begin
        o_perf_replaced <= o_perf_replaced + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_squash_arbiter.sv
// Testbench for squash_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural reference model.
module tb_squash_arbiter;
  localparam int NUM_BRU      = 2;
  localparam int ROB_IDX_W    = 7;
  localparam int FOLDPC_W     = 10;
  localparam int XLEN         = 64;
  localparam int FLUSH_CYCLES = 3;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_BRU-1:0]           i_bru_vld;
  logic [NUM_BRU-1:0]           i_bru_mispred;
  logic [NUM_BRU-1:0]           i_bru_taken;
  logic [NUM_BRU*ROB_IDX_W-1:0] i_bru_rob_idx;
  logic [NUM_BRU*XLEN-1:0]      i_bru_npc;
  logic                         i_viol_vld;
  logic [ROB_IDX_W-1:0]         i_viol_rob_idx;
  logic [XLEN-1:0]              i_viol_load_pc;
  logic [FOLDPC_W-1:0]          i_viol_store_foldpc;
  logic [FOLDPC_W-1:0]          i_viol_load_foldpc;
  logic                         i_commit_vld;
  logic [ROB_IDX_W-1:0]         i_commit_rob_idx;
  logic                         o_squash_vld;
  logic                         o_squash_branch;
  logic                         o_squash_viol;
  logic                         o_squash_taken;
  logic [XLEN-1:0]              o_squash_pc;
  logic [FOLDPC_W-1:0]          o_squash_store_foldpc;
  logic [FOLDPC_W-1:0]          o_squash_load_foldpc;
  logic                         o_pending;
  logic [ROB_IDX_W-1:0]         o_pending_rob_idx;
`ifdef SQUASH_ARBITER_PERF_EN
  logic [31:0] o_perf_br_squash, o_perf_viol_squash, o_perf_replaced;
`endif

  always #5 clk = ~clk;

  squash_arbiter #(
    .NUM_BRU(NUM_BRU), .ROB_IDX_W(ROB_IDX_W), .FOLDPC_W(FOLDPC_W),
    .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .i_bru_vld(i_bru_vld), .i_bru_mispred(i_bru_mispred), .i_bru_taken(i_bru_taken),
    .i_bru_rob_idx(i_bru_rob_idx), .i_bru_npc(i_bru_npc),
    .i_viol_vld(i_viol_vld), .i_viol_rob_idx(i_viol_rob_idx), .i_viol_load_pc(i_viol_load_pc),
    .i_viol_store_foldpc(i_viol_store_foldpc), .i_viol_load_foldpc(i_viol_load_foldpc),
    .i_commit_vld(i_commit_vld), .i_commit_rob_idx(i_commit_rob_idx),
    .o_squash_vld(o_squash_vld), .o_squash_branch(o_squash_branch), .o_squash_viol(o_squash_viol),
    .o_squash_taken(o_squash_taken), .o_squash_pc(o_squash_pc),
    .o_squash_store_foldpc(o_squash_store_foldpc), .o_squash_load_foldpc(o_squash_load_foldpc),
    .o_pending(o_pending), .o_pending_rob_idx(o_pending_rob_idx)
`ifdef SQUASH_ARBITER_PERF_EN
    , .o_perf_br_squash(o_perf_br_squash), .o_perf_viol_squash(o_perf_viol_squash),
    .o_perf_replaced(o_perf_replaced)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend;
  logic [6:0]  m_idx;
  bit          m_branch, m_taken;
  logic [63:0] m_pc;
  logic [9:0]  m_sf, m_lf;
  int          m_flush;
  int          m_br_cnt, m_viol_cnt, m_repl_cnt;
  int          pend_age;
  // Expected squash packet after the next edge
  bit          e_vld, e_branch, e_viol, e_taken;
  logic [63:0] e_pc;
  logic [9:0]  e_sf, e_lf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a is older than b when b lies 1..63 slots after a on the 128-entry ring
  function automatic bit ref_older(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = b - a;
    return (d >= 7'd1) && (d <= 7'd63);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_idx = '0; m_branch = 0; m_taken = 0; m_pc = '0; m_sf = '0; m_lf = '0;
    m_flush = 0; m_br_cnt = 0; m_viol_cnt = 0; m_repl_cnt = 0; pend_age = 0;
    e_vld = 0; e_branch = 0; e_viol = 0; e_taken = 0; e_pc = '0; e_sf = '0; e_lf = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit          cv [NUM_BRU+1];
    logic [6:0]  ci [NUM_BRU+1];
    logic [6:0]  anchor;
    bit          found;
    int          best, best_key, key;
    e_vld = 0; e_branch = 0; e_viol = 0; e_taken = 0; e_pc = '0; e_sf = '0; e_lf = '0;
    if (m_flush > 0) begin
      m_flush--;
      return;
    end
    if (m_pend && i_commit_vld && (i_commit_rob_idx == m_idx)) begin
      e_vld = 1; e_branch = m_branch; e_viol = !m_branch; e_taken = m_taken;
      e_pc = m_pc; e_sf = m_sf; e_lf = m_lf;
      if (m_branch) m_br_cnt++; else m_viol_cnt++;
      m_pend = 0; m_flush = FLUSH_CYCLES;
      return;
    end
    for (int p = 0; p < NUM_BRU; p++) begin
      cv[p] = i_bru_vld[p] && i_bru_mispred[p];
      ci[p] = i_bru_rob_idx[p*7 +: 7];
    end
    cv[NUM_BRU] = i_viol_vld;
    ci[NUM_BRU] = i_viol_rob_idx;
    found = 0; anchor = '0; best = 0; best_key = 1 << 30;
    for (int s = 0; s <= NUM_BRU; s++) if (cv[s] && !found) begin anchor = ci[s]; found = 1; end
    // Rank by ring distance from an anchor; slot number breaks ties
    // (ports before the violation, lower ports first).
    for (int s = 0; s <= NUM_BRU; s++) begin
      if (cv[s]) begin
        key = (((int'(ci[s]) - int'(anchor) + 64) & 127) * 8) + s;
        if (key < best_key) begin best_key = key; best = s; end
      end
    end
    if (found && (!m_pend || ref_older(ci[best], m_idx))) begin
      if (m_pend) m_repl_cnt++;
      m_pend = 1; m_idx = ci[best];
      if (best < NUM_BRU) begin
        m_branch = 1; m_taken = i_bru_taken[best]; m_pc = i_bru_npc[best*64 +: 64];
        m_sf = '0; m_lf = '0;
      end else begin
        m_branch = 0; m_taken = 0; m_pc = i_viol_load_pc;
        m_sf = i_viol_store_foldpc; m_lf = i_viol_load_foldpc;
      end
    end
  endtask

  task automatic check_all();
    chk("squash_vld", o_squash_vld, e_vld);
    chk("squash_branch", o_squash_branch, e_branch);
    chk("squash_viol", o_squash_viol, e_viol);
    chk("squash_taken", o_squash_taken, e_taken);
    chk("squash_pc", o_squash_pc, e_pc);
    chk("squash_sfold", o_squash_store_foldpc, e_sf);
    chk("squash_lfold", o_squash_load_foldpc, e_lf);
    chk("pending", o_pending, m_pend);
    chk("pending_idx", o_pending_rob_idx, m_pend ? m_idx : 7'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (m_pend) pend_age++; else pend_age = 0;
  endtask

  task automatic clr_in();
    i_bru_vld = '0; i_bru_mispred = '0; i_bru_taken = '0; i_bru_rob_idx = '0; i_bru_npc = '0;
    i_viol_vld = 1'b0; i_viol_rob_idx = '0; i_viol_load_pc = '0;
    i_viol_store_foldpc = '0; i_viol_load_foldpc = '0;
    i_commit_vld = 1'b0; i_commit_rob_idx = '0;
  endtask

  task automatic bru(input int p, input logic [6:0] idx, input logic [63:0] npc, input bit tk);
    i_bru_vld[p] = 1'b1; i_bru_mispred[p] = 1'b1; i_bru_taken[p] = tk;
    i_bru_rob_idx[p*7 +: 7] = idx; i_bru_npc[p*64 +: 64] = npc;
  endtask

  task automatic viol(input logic [6:0] idx, input logic [63:0] pc, input logic [9:0] sf, input logic [9:0] lf);
    i_viol_vld = 1'b1; i_viol_rob_idx = idx; i_viol_load_pc = pc;
    i_viol_store_foldpc = sf; i_viol_load_foldpc = lf;
  endtask

  task automatic commit(input logic [6:0] idx);
    i_commit_vld = 1'b1; i_commit_rob_idx = idx;
  endtask

  task automatic idle(input int n);
    clr_in();
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [6:0] base;

  initial begin
    clr_in();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pending", o_pending, 1'b0);
    rst = 1'b0;

    // Basic branch mispredict squash
    bru(0, 7'h05, 64'h8000_1000, 1'b1); tick(); clr_in();
    chk("t1_pend_idx", o_pending_rob_idx, 7'h05);
    idle(2);
    commit(7'h05); tick(); clr_in();
    chk("t1_vld", o_squash_vld, 1'b1);
    chk("t1_branch", o_squash_branch, 1'b1);
    chk("t1_pc", o_squash_pc, 64'h8000_1000);
    chk("t1_taken", o_squash_taken, 1'b1);
    // Candidate during flush is dropped and never squashes later
    for (int k = 0; k < FLUSH_CYCLES; k++) begin
      viol(7'h33, 64'h1234, 10'h001, 10'h002); tick();
      chk("t5_flush_pend", o_pending, 1'b0);
      chk("t5_vld_once", o_squash_vld, 1'b0);
    end
    clr_in(); tick();
    commit(7'h33); tick(); clr_in();
    chk("t5_no_squash", o_squash_vld, 1'b0);
    chk("t5_no_pend", o_pending, 1'b0);

    // Two ports same cycle, older one wins; non-matching commit ignored
    bru(0, 7'h10, 64'h0000_AAAA, 1'b0); bru(1, 7'h0C, 64'h0000_BBBB, 1'b1); tick(); clr_in();
    chk("t2_pend_idx", o_pending_rob_idx, 7'h0C);
    commit(7'h10); tick(); clr_in();
    chk("t2_nomatch", o_squash_vld, 1'b0);
    commit(7'h0C); tick(); clr_in();
    chk("t2_vld", o_squash_vld, 1'b1);
    chk("t2_pc", o_squash_pc, 64'h0000_BBBB);
    // Flush lasts exactly FLUSH_CYCLES cycles
    for (int k = 0; k <= FLUSH_CYCLES; k++) begin
      bru(0, 7'h40, 64'h0000_4040, 1'b0); tick();
    end
    clr_in();
    chk("t2_after_flush", o_pending_rob_idx, 7'h40);

    // Branch pending replaced by an older violation
    bru(0, 7'h20, 64'h0000_2020, 1'b1); tick(); clr_in();
    chk("t3_pend_br", o_pending_rob_idx, 7'h20);
    viol(7'h1A, 64'h8000_2000, 10'h155, 10'h2AA); tick(); clr_in();
    chk("t3_pend_viol", o_pending_rob_idx, 7'h1A);
    commit(7'h1A); tick(); clr_in();
    chk("t3_viol", o_squash_viol, 1'b1);
    chk("t3_branch", o_squash_branch, 1'b0);
    chk("t3_pc", o_squash_pc, 64'h8000_2000);
    chk("t3_sfold", o_squash_store_foldpc, 10'h155);
    chk("t3_lfold", o_squash_load_foldpc, 10'h2AA);
    idle(FLUSH_CYCLES);

    // Wrap-around age compare
    bru(0, 7'h7E, 64'h7E7E, 1'b0); tick(); clr_in();
    bru(0, 7'h01, 64'h0101, 1'b0); tick(); clr_in();
    chk("t4_keep_7e", o_pending_rob_idx, 7'h7E);
    commit(7'h7E); tick(); clr_in();
    chk("t4_sq_7e", o_squash_pc, 64'h7E7E);
    idle(FLUSH_CYCLES);
    bru(1, 7'h01, 64'h0101, 1'b1); tick(); clr_in();
    viol(7'h7E, 64'h9999, 10'h011, 10'h022); tick(); clr_in();
    chk("t4_repl_7e", o_pending_rob_idx, 7'h7E);
    viol(7'h7F, 64'h5555, 10'h0, 10'h0); bru(0, 7'h7F, 64'h6666, 1'b0); tick(); clr_in();
    chk("t4_younger_drop", o_pending_rob_idx, 7'h7E);
    commit(7'h7E); tick(); clr_in();
    chk("t4_sq_viol", o_squash_viol, 1'b1);
    idle(FLUSH_CYCLES);

    // Same-cycle commit match and older candidate: commit wins
    bru(0, 7'h50, 64'h5050, 1'b1); tick(); clr_in();
    commit(7'h50); bru(1, 7'h4F, 64'h4F4F, 1'b0); tick(); clr_in();
    chk("t7_pc", o_squash_pc, 64'h5050);
    chk("t7_pend", o_pending, 1'b0);
    idle(FLUSH_CYCLES + 1);

    // Asynchronous reset while pending
    bru(0, 7'h15, 64'h1515, 1'b1); tick(); clr_in();
    chk("t6_pend", o_pending, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    commit(7'h15); tick(); clr_in();
    chk("t6_no_squash", o_squash_vld, 1'b0);
    idle(2);

    // Randomized traffic, indices kept within a sliding window on the ring
    base = 7'h70;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clr_in();
      if ((cyc % 8) == 7) base = base + 7'd1;
      for (int p = 0; p < NUM_BRU; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          i_bru_vld[p] = 1'b1;
          i_bru_mispred[p] = 1'($urandom_range(0, 1));
          i_bru_taken[p] = 1'($urandom_range(0, 1));
          i_bru_rob_idx[p*7 +: 7] = base + 7'($urandom_range(0, 40));
          i_bru_npc[p*64 +: 64] = {$urandom, $urandom};
        end
      end
      if ($urandom_range(0, 4) == 0)
        viol(base + 7'($urandom_range(0, 40)), {$urandom, $urandom}, 10'($urandom), 10'($urandom));
      if (m_pend && (pend_age > 10)) commit(m_idx);
      else if ($urandom_range(0, 1) == 0)
        commit((m_pend && $urandom_range(0, 1) == 1) ? m_idx : base + 7'($urandom_range(0, 40)));
      tick();
    end
    clr_in();

`ifdef SQUASH_ARBITER_PERF_EN
    chk("perf_br", o_perf_br_squash, 64'(m_br_cnt));
    chk("perf_viol", o_perf_viol_squash, 64'(m_viol_cnt));
    chk("perf_repl", o_perf_replaced, 64'(m_repl_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
